// File: rtl/axis_spi_slave.sv
// SPI target endpoint: MOSI words leave on m_axis, s_axis words shift out on MISO.
// Optional sticky overrun/underrun status ports when AXIS_SPI_SLAVE_STATUS_EN is defined.
module axis_spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
`ifdef AXIS_SPI_SLAVE_STATUS_EN
    ,
    output logic                  overrun_o,
    output logic                  underrun_o
`endif
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_c_q, sclk_c_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_c_q, cs_c_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   mosi_c_q, mosi_c_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [DATA_WIDTH-2:0]  rx_q, rx_d;
    logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic                   m_tvalid_q, m_tvalid_d;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
    logic                   overrun_q, overrun_d;
    logic                   underrun_q, underrun_d;
`endif

    logic                   sclk_rise, sclk_fall, lead_e, trail_e;
    logic                   sample_e, shift_e, cs_fall;
    logic                   tx_load, word_done;
    logic [DATA_WIDTH-1:0]  rx_next;

    // Edge detect runs one register behind the synchronizer so that every
    // pin-driven action lands SYNC_STAGES+2 cycles after the pin edge.
    assign sclk_rise = sclk_c_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_c_q & sclk_prev_q;
    assign lead_e    = cpol_q ? sclk_fall : sclk_rise;
    assign trail_e   = cpol_q ? sclk_rise : sclk_fall;
    assign sample_e  = cpha_q ? trail_e : lead_e;
    assign shift_e   = cpha_q ? lead_e : trail_e;
    assign cs_fall   = ~cs_c_q & cs_prev_q;
    assign rx_next   = {rx_q, mosi_c_q};

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        sclk_c_d      = sclk_sync_q[SYNC_STAGES-1];
        cs_c_d        = cs_sync_q[SYNC_STAGES-1];
        mosi_c_d      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d   = sclk_c_q;
        cs_prev_d     = cs_c_q;
        state_d       = state_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        bit_cnt_d     = bit_cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        m_tdata_d     = m_tdata_q;
        m_tvalid_d    = m_tvalid_q;
        tx_load       = 1'b0;
        word_done     = 1'b0;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
        overrun_d     = overrun_q;
        underrun_d    = underrun_q;
`endif

        if (m_tvalid_q && m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
                    overrun_d  = 1'b0;
                    underrun_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                tx_load   = 1'b1;
                bit_cnt_d = '0;
                rx_d      = '0;
                state_d   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cs_c_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (sample_e) begin
                    rx_d = rx_next[DATA_WIDTH-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                        tx_load   = cpha_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (shift_e) begin
                    // Counter at zero means either the first CPHA=1 edge (MSB already
                    // on the pin) or the CPHA=0 edge right after a completed word.
                    if (bit_cnt_q == '0) begin
                        tx_load = ~cpha_q;
                    end else begin
                        tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tx_load) begin
            if (s_axis_tvalid) begin
                tx_d = s_axis_tdata;
            end else begin
                tx_d = '0;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
                underrun_d = 1'b1;
`endif
            end
        end

        if (word_done) begin
            if (!m_tvalid_q || m_axis_tready) begin
                m_tdata_d  = rx_next;
                m_tvalid_d = 1'b1;
            end else begin
`ifdef AXIS_SPI_SLAVE_STATUS_EN
                overrun_d = 1'b1;
`endif
            end
        end

        s_axis_tready = tx_load & s_axis_tvalid & ~rst_i;
    end

    // CS sync resets low so a CS already held low at reset release is not seen as a fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_c_q    <= 1'b0;
            cs_c_q      <= 1'b0;
            mosi_c_q    <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_c_q    <= sclk_c_d;
            cs_c_q      <= cs_c_d;
            mosi_c_q    <= mosi_c_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
`endif
        end
    end

    assign spi_miso_o    = tx_q[DATA_WIDTH-1];
    assign spi_miso_oe_o = (state_q != ST_IDLE);
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
    assign overrun_o     = overrun_q;
    assign underrun_o    = underrun_q;
`endif

endmodule

// File: tb/tb_axis_spi_slave.sv
// Bench for axis_spi_slave: bit-banged SPI master, s_axis source queue, m_axis scoreboard.
module tb_axis_spi_slave;

    localparam int DW   = 8;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cpol_i, cpha_i;
    logic          spi_sclk_i, spi_cs_n_i, spi_mosi_i;
    logic          spi_miso_o, spi_miso_oe_o;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready;
`ifdef AXIS_SPI_SLAVE_STATUS_EN
    logic          overrun_o, underrun_o;
`endif

    always #5 clk = ~clk;

    axis_spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpol_i        (cpol_i),
        .cpha_i        (cpha_i),
        .spi_sclk_i    (spi_sclk_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef AXIS_SPI_SLAVE_STATUS_EN
        ,
        .overrun_o     (overrun_o),
        .underrun_o    (underrun_o)
`endif
    );

    int            total = 0;
    int            bad = 0;
    int            rx_seen = 0;
    int            tready_pulses = 0;
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] tx_src[$];
    logic [DW-1:0] m_tx[4];
    logic [DW-1:0] m_rx[4];

    typedef struct {
        bit            pol;
        bit            pha;
        logic [DW-1:0] mword;
        logic [DW-1:0] sword;
        bit            svalid;
        logic [DW-1:0] exp_miso;
        int            exp_pulses;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // s_axis source: present queue head, retire it after each accepted handshake.
    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        forever begin
            bit hs;
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(tx_src.pop_front());
                tready_pulses++;
            end
            s_axis_tvalid = (tx_src.size() > 0);
            s_axis_tdata  = (tx_src.size() > 0) ? tx_src[0] : '0;
        end
    end

    // m_axis scoreboard: every accepted word must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                rx_seen++;
                if (exp_rx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL m_axis_unexpected: got 0x%0h expected none", m_axis_tdata);
                end else begin
                    check("m_axis_tdata", 32'(m_axis_tdata), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic spi_bit(input bit pol, input bit pha, input bit mo, output bit mi);
        if (!pha) begin
            spi_mosi_i = mo;
            repeat (HALF) @(negedge clk);
            mi = spi_miso_o;
            spi_sclk_i = ~pol;
            repeat (HALF) @(negedge clk);
            spi_sclk_i = pol;
        end else begin
            spi_sclk_i = ~pol;
            spi_mosi_i = mo;
            repeat (HALF) @(negedge clk);
            mi = spi_miso_o;
            spi_sclk_i = pol;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // One CS frame of nwords; stop_bits > 0 raises CS after that many bits.
    task automatic spi_frame(input bit pol, input bit pha, input int nwords, input int stop_bits);
        int n;
        bit mi;
        n = 0;
        cpol_i     = pol;
        cpha_i     = pha;
        spi_sclk_i = pol;
        repeat (6) @(negedge clk);
        spi_cs_n_i = 1'b0;
        repeat (12) @(negedge clk);
        for (int w = 0; w < nwords; w++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                if (!(stop_bits > 0 && n >= stop_bits)) begin
                    spi_bit(pol, pha, m_tx[w][b], mi);
                    m_rx[w][b] = mi;
                    n++;
                end
            end
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n_i = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(spi_miso_o), 32'd0);
        check({tag, "_oe"}, 32'(spi_miso_oe_o), 32'd0);
        check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
        check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    endtask

    initial begin
        int  p0, r0;
        bit  mi;

        tbl[0] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 1'b1, 8'hA5, 1};
        tbl[1] = '{1'b0, 1'b1, 8'h96, 8'h0F, 1'b1, 8'h0F, 1};
        tbl[2] = '{1'b1, 1'b0, 8'h01, 8'h80, 1'b1, 8'h80, 1};
        tbl[3] = '{1'b1, 1'b1, 8'hE7, 8'h42, 1'b1, 8'h42, 1};
        tbl[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 0};
        tbl[5] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF, 1};

        rst_i         = 1'b1;
        cpol_i        = 1'b0;
        cpha_i        = 1'b0;
        spi_sclk_i    = 1'b0;
        spi_cs_n_i    = 1'b1;
        spi_mosi_i    = 1'b0;
        m_axis_tready = 1'b1;
        repeat (5) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Single-word frames in every mode, including an underrun.
        for (int i = 0; i < 6; i++) begin
            p0 = tready_pulses;
            r0 = rx_seen;
            if (tbl[i].svalid) tx_src.push_back(tbl[i].sword);
            exp_rx.push_back(tbl[i].mword);
            m_tx[0] = tbl[i].mword;
            spi_frame(tbl[i].pol, tbl[i].pha, 1, 0);
            check($sformatf("miso_word[%0d]", i), 32'(m_rx[0]), 32'(tbl[i].exp_miso));
            check($sformatf("tready_pulses[%0d]", i), 32'(tready_pulses - p0), 32'(tbl[i].exp_pulses));
            check($sformatf("rx_words[%0d]", i), 32'(rx_seen - r0), 32'd1);
`ifdef AXIS_SPI_SLAVE_STATUS_EN
            if (!tbl[i].svalid) check($sformatf("underrun_flag[%0d]", i), 32'(underrun_o), 32'd1);
`endif
        end

        // Mode 3, two words back to back in one frame.
        p0 = tready_pulses;
        r0 = rx_seen;
        tx_src.push_back(8'h55);
        tx_src.push_back(8'hAA);
        exp_rx.push_back(8'h81);
        exp_rx.push_back(8'h7E);
        m_tx[0] = 8'h81;
        m_tx[1] = 8'h7E;
        spi_frame(1'b1, 1'b1, 2, 0);
        check("b2b_miso0", 32'(m_rx[0]), 32'h55);
        check("b2b_miso1", 32'(m_rx[1]), 32'hAA);
        check("b2b_pulses", 32'(tready_pulses - p0), 32'd2);
        check("b2b_rx_words", 32'(rx_seen - r0), 32'd2);

        // Overrun: downstream stalled, second word must be dropped.
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
        r0 = rx_seen;
        exp_rx.push_back(8'h11);
        m_tx[0] = 8'h11;
        m_tx[1] = 8'h22;
        spi_frame(1'b0, 1'b0, 2, 0);
        check("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("ovr_tdata", 32'(m_axis_tdata), 32'h11);
`ifdef AXIS_SPI_SLAVE_STATUS_EN
        check("ovr_flag", 32'(overrun_o), 32'd1);
`endif
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
        repeat (6) @(negedge clk);
        check("ovr_rx_words", 32'(rx_seen - r0), 32'd1);
        check("ovr_tvalid_clear", 32'(m_axis_tvalid), 32'd0);

        // CS aborted after 5 bits, then a full frame.
        r0 = rx_seen;
        m_tx[0] = 8'hFF;
        spi_frame(1'b0, 1'b0, 1, 5);
        check("abort_rx_words", 32'(rx_seen - r0), 32'd0);
        tx_src.push_back(8'h5C);
        exp_rx.push_back(8'hC3);
        m_tx[0] = 8'hC3;
        spi_frame(1'b0, 1'b0, 1, 0);
        check("abort_next_miso", 32'(m_rx[0]), 32'h5C);
        check("abort_next_rx_words", 32'(rx_seen - r0), 32'd1);
`ifdef AXIS_SPI_SLAVE_STATUS_EN
        check("ovr_flag_cleared", 32'(overrun_o), 32'd0);
`endif

        // Reset mid-word, then CS held low must not start a frame.
        tx_src.push_back(8'hFF);
        cpol_i     = 1'b0;
        cpha_i     = 1'b0;
        spi_sclk_i = 1'b0;
        repeat (6) @(negedge clk);
        spi_cs_n_i = 1'b0;
        repeat (12) @(negedge clk);
        for (int b = 0; b < 4; b++) spi_bit(1'b0, 1'b0, 1'b1, mi);
        check("pre_rst_oe", 32'(spi_miso_oe_o), 32'd1);
        check("pre_rst_miso", 32'(spi_miso_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_i = 1'b0;
        r0 = rx_seen;
        for (int b = 0; b < DW; b++) spi_bit(1'b0, 1'b0, 1'b1, mi);
        repeat (HALF) @(negedge clk);
        check("post_rst_oe", 32'(spi_miso_oe_o), 32'd0);
        check("post_rst_rx_words", 32'(rx_seen - r0), 32'd0);
        spi_cs_n_i = 1'b1;
        repeat (12) @(negedge clk);

        tx_src.push_back(8'h3D);
        exp_rx.push_back(8'h5A);
        m_tx[0] = 8'h5A;
        spi_frame(1'b0, 1'b1, 1, 0);
        check("mode1_miso", 32'(m_rx[0]), 32'h3D);
        check("mode1_rx_words", 32'(rx_seen - r0), 32'd1);

        for (int i = 0; i < 50 && exp_rx.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(exp_rx.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
